ex_mem_stage_reg: RTL and testbench
===================================

// Module: ex_mem_stage_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register for the pipelined core; replaces the fixed 32-bit stage latch.
//  Adds a valid bit, stall (hold) and flush (bubble) control, and squashes write-enables on bubbles.
//  Provides saturating stall/bubble performance counters for hazard-unit debug.
//  Sits between the ALU/operand-mux stage and the data memory / writeback select logic.
// PARAMETERS
//  DATA_W      32  width of ALU result, store data (muxB) and next-PC fields
//  ADDR_W      16  width of data-memory address field
//  SEL_W        2  width of RF_D_SEL and RD_SEL fields
//  CNT_W       16  width of each performance counter
//  CLR_ON_BUB   0  1: data fields load 0 on a bubble/flush; 0: data fields keep their previous value
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  stall        in   1       hold all stage contents this cycle
//  flush        in   1       insert bubble this cycle (overrides stall)
//  cnt_clr      in   1       synchronous clear of both counters
//  EX_VALID     in   1       EX stage holds a real instruction
//  EX_DM_WE     in   1       data-memory write enable
//  EX_RF_WE     in   1       register-file write enable
//  EX_ALU_RES   in   DATA_W  ALU result
//  EX_muxB      in   DATA_W  store data
//  EX_DM_ADDR   in   ADDR_W  data-memory address
//  EX_RF_D_SEL  in   SEL_W   writeback data select
//  EX_NEXT_PC   in   DATA_W  PC+1 for link writeback
//  EX_RD_SEL    in   SEL_W   destination register select
//  MEM_VALID    out  1       registered valid
//  MEM_DM_WE    out  1       registered DM write enable, 0 whenever MEM_VALID=0
//  MEM_RF_WE    out  1       registered RF write enable, 0 whenever MEM_VALID=0
//  MEM_ALU_RES, MEM_muxB, MEM_DM_ADDR, MEM_RF_D_SEL, MEM_NEXT_PC, MEM_RD_SEL  out  (as EX_*)  registered fields
//  stall_cnt    out  CNT_W   cycles spent stalled (saturating)
//  bubble_cnt   out  CNT_W   bubbles inserted (saturating)
// BEHAVIOUR
//  - All outputs registered on posedge clk; latency 1 cycle EX->MEM; no combinational path input->output.
//  - Reset (rst=1): every output, both counters and MEM_VALID = 0; overrides all other inputs.
//  - Per-cycle priority: rst > flush > stall > load.
//  - flush=1: MEM_VALID, MEM_DM_WE, MEM_RF_WE <= 0; data fields <= 0 if CLR_ON_BUB=1 else hold; bubble_cnt +1.
//  - stall=1, flush=0: every output register holds (including MEM_VALID); stall_cnt +1.
//  - load (stall=0, flush=0): MEM_VALID <= EX_VALID; MEM_DM_WE <= EX_DM_WE & EX_VALID;
//    MEM_RF_WE <= EX_RF_WE & EX_VALID; data fields <= EX_* (if EX_VALID=0 and CLR_ON_BUB=1, data <= 0).
//  - load with EX_VALID=0 counts as a bubble: bubble_cnt +1.
//  - Invariant: MEM_VALID=0 implies MEM_DM_WE=0 and MEM_RF_WE=0, every cycle.
//  - Counters saturate at 2**CNT_W-1, never wrap. cnt_clr=1 zeroes both; cnt_clr wins over same-cycle increment.
//  - stall and flush together: flush wins; only bubble_cnt increments, stall_cnt unchanged.
//  - rst asserted mid-stall or mid-flush: next cycle all zero; first load after rst deasserts proceeds normally.
//  - Field widths are passed through unchanged; no sign/zero extension inside the block.
// TESTING
//  1 rst=1 for 2 cycles with random EX_* -> all outputs and counters 0.
//  2 EX_VALID=1, EX_ALU_RES=0x12345678, EX_DM_WE=1, EX_RD_SEL=2 -> next cycle MEM_ALU_RES=0x12345678, MEM_DM_WE=1, MEM_VALID=1.
//  3 load one instr, then stall=1 for 3 cycles while EX_* changes -> MEM_* unchanged for 3 cycles, stall_cnt=3.
//  4 stall=1 and flush=1 same cycle with EX_DM_WE=1 -> MEM_VALID=0, MEM_DM_WE=0, bubble_cnt=1, stall_cnt unchanged.
//  5 EX_VALID=0, EX_DM_WE=1, EX_RF_WE=1 -> MEM_DM_WE=0, MEM_RF_WE=0; CLR_ON_BUB=1 build: MEM_ALU_RES=0.
//  6 CNT_W=4, stall held 20 cycles -> stall_cnt stops at 15; cnt_clr=1 with stall=1 -> stall_cnt=0 next cycle.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_reg
//
// Purpose:
//   EX->MEM pipeline register for the pipelined core. It carries the ALU
//   result, store data, data-memory address, writeback selects and next-PC
//   from the execute stage to the memory stage. It adds a valid bit, a stall
//   (hold) and a flush (bubble) control, and it forces the write enables to
//   zero on every bubble. Two saturating counters record stall cycles and
//   inserted bubbles for hazard-unit debug.
//
// Parameters:
//   DATA_W     width of ALU result, store data and next-PC fields
//   ADDR_W     width of the data-memory address field
//   SEL_W      width of the RF_D_SEL and RD_SEL fields
//   CNT_W      width of each performance counter
//   CLR_ON_BUB 1: data fields load 0 on a bubble; 0: data fields keep value
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold every stage register this cycle
//   flush               insert a bubble this cycle (wins over stall)
//   cnt_clr             synchronous clear of both counters
//   EX_*                execute-stage inputs
//   MEM_*               registered memory-stage outputs (1-cycle latency)
//   stall_cnt           cycles spent stalled (saturating)
//   bubble_cnt          bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module ex_mem_stage_reg #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned CNT_W      = 16,
   parameter bit          CLR_ON_BUB = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              cnt_clr,
   input  logic              EX_VALID,
   input  logic              EX_DM_WE,
   input  logic              EX_RF_WE,
   input  logic [DATA_W-1:0] EX_ALU_RES,
   input  logic [DATA_W-1:0] EX_muxB,
   input  logic [ADDR_W-1:0] EX_DM_ADDR,
   input  logic [SEL_W-1:0]  EX_RF_D_SEL,
   input  logic [DATA_W-1:0] EX_NEXT_PC,
   input  logic [SEL_W-1:0]  EX_RD_SEL,
   output logic              MEM_VALID,
   output logic              MEM_DM_WE,
   output logic              MEM_RF_WE,
   output logic [DATA_W-1:0] MEM_ALU_RES,
   output logic [DATA_W-1:0] MEM_muxB,
   output logic [ADDR_W-1:0] MEM_DM_ADDR,
   output logic [SEL_W-1:0]  MEM_RF_D_SEL,
   output logic [DATA_W-1:0] MEM_NEXT_PC,
   output logic [SEL_W-1:0]  MEM_RD_SEL,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Per-cycle action decode; priority is flush > stall > load.
   logic do_load;
   logic stall_evt;
   logic bubble_evt;
   logic clr_data;

   // NOTE: every signal driven in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      do_load    = 1'b0;
      stall_evt  = 1'b0;
      bubble_evt = 1'b0;
      clr_data   = 1'b0;
      if (flush) begin
         bubble_evt = 1'b1;
         clr_data   = CLR_ON_BUB;
      end else if (stall) begin
         stall_evt  = 1'b1;
      end else begin
         do_load    = 1'b1;
         // Loading an empty slot is also a bubble in the MEM stage.
         bubble_evt = ~EX_VALID;
         clr_data   = CLR_ON_BUB & ~EX_VALID;
      end
   end

   // Valid and write enables. The enables are qualified with the valid bit
   // on load and cleared on flush, so MEM_VALID=0 always implies both are 0.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         MEM_VALID <= 1'b0;
         MEM_DM_WE <= 1'b0;
         MEM_RF_WE <= 1'b0;
      end else if (flush) begin
         MEM_VALID <= 1'b0;
         MEM_DM_WE <= 1'b0;
         MEM_RF_WE <= 1'b0;
      end else if (do_load) begin
         MEM_VALID <= EX_VALID;
         MEM_DM_WE <= EX_DM_WE & EX_VALID;
         MEM_RF_WE <= EX_RF_WE & EX_VALID;
      end
   end

   // Data fields: hold on stall, and on flush unless CLR_ON_BUB clears them.
   // NOTE: these are plain registers, not a memory array, so they take the
   // synchronous reset like every other output register.
   always_ff @(posedge clk) begin
      if (rst || clr_data) begin
         MEM_ALU_RES  <= '0;
         MEM_muxB     <= '0;
         MEM_DM_ADDR  <= '0;
         MEM_RF_D_SEL <= '0;
         MEM_NEXT_PC  <= '0;
         MEM_RD_SEL   <= '0;
      end else if (do_load) begin
         MEM_ALU_RES  <= EX_ALU_RES;
         MEM_muxB     <= EX_muxB;
         MEM_DM_ADDR  <= EX_DM_ADDR;
         MEM_RF_D_SEL <= EX_RF_D_SEL;
         MEM_NEXT_PC  <= EX_NEXT_PC;
         MEM_RD_SEL   <= EX_RD_SEL;
      end
   end

   // Saturating performance counters; cnt_clr wins over an increment.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (bubble_evt && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_reg
//
// Directed bench for ex_mem_stage_reg. Two instances share one set of
// inputs: dut_a uses the default parameters (CLR_ON_BUB=0, CNT_W=16) and
// dut_b uses CLR_ON_BUB=1, CNT_W=4 so data clearing and counter saturation
// are both visible. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_reg;

   logic        clk = 1'b0;
   logic        rst, stall, flush, cnt_clr;
   logic        ex_valid, ex_dm_we, ex_rf_we;
   logic [31:0] ex_alu_res, ex_muxb, ex_next_pc;
   logic [15:0] ex_dm_addr;
   logic [1:0]  ex_rf_d_sel, ex_rd_sel;

   logic        a_valid, a_dm_we, a_rf_we;
   logic [31:0] a_alu_res, a_muxb, a_next_pc;
   logic [15:0] a_dm_addr;
   logic [1:0]  a_rf_d_sel, a_rd_sel;
   logic [15:0] a_stall_cnt, a_bubble_cnt;

   logic        b_valid, b_dm_we, b_rf_we;
   logic [31:0] b_alu_res, b_muxb, b_next_pc;
   logic [15:0] b_dm_addr;
   logic [1:0]  b_rf_d_sel, b_rd_sel;
   logic [3:0]  b_stall_cnt, b_bubble_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ex_mem_stage_reg dut_a (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .EX_VALID(ex_valid), .EX_DM_WE(ex_dm_we), .EX_RF_WE(ex_rf_we),
      .EX_ALU_RES(ex_alu_res), .EX_muxB(ex_muxb), .EX_DM_ADDR(ex_dm_addr),
      .EX_RF_D_SEL(ex_rf_d_sel), .EX_NEXT_PC(ex_next_pc), .EX_RD_SEL(ex_rd_sel),
      .MEM_VALID(a_valid), .MEM_DM_WE(a_dm_we), .MEM_RF_WE(a_rf_we),
      .MEM_ALU_RES(a_alu_res), .MEM_muxB(a_muxb), .MEM_DM_ADDR(a_dm_addr),
      .MEM_RF_D_SEL(a_rf_d_sel), .MEM_NEXT_PC(a_next_pc), .MEM_RD_SEL(a_rd_sel),
      .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
   );

   ex_mem_stage_reg #(.CNT_W(4), .CLR_ON_BUB(1'b1)) dut_b (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
      .EX_VALID(ex_valid), .EX_DM_WE(ex_dm_we), .EX_RF_WE(ex_rf_we),
      .EX_ALU_RES(ex_alu_res), .EX_muxB(ex_muxb), .EX_DM_ADDR(ex_dm_addr),
      .EX_RF_D_SEL(ex_rf_d_sel), .EX_NEXT_PC(ex_next_pc), .EX_RD_SEL(ex_rd_sel),
      .MEM_VALID(b_valid), .MEM_DM_WE(b_dm_we), .MEM_RF_WE(b_rf_we),
      .MEM_ALU_RES(b_alu_res), .MEM_muxB(b_muxb), .MEM_DM_ADDR(b_dm_addr),
      .MEM_RF_D_SEL(b_rf_d_sel), .MEM_NEXT_PC(b_next_pc), .MEM_RD_SEL(b_rd_sel),
      .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs are then sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic dm, input logic rf,
                         input logic [31:0] alu, input logic [31:0] mb,
                         input logic [15:0] addr, input logic [1:0] dsel,
                         input logic [31:0] npc, input logic [1:0] rd);
      ex_valid    = v;
      ex_dm_we    = dm;
      ex_rf_we    = rf;
      ex_alu_res  = alu;
      ex_muxb     = mb;
      ex_dm_addr  = addr;
      ex_rf_d_sel = dsel;
      ex_next_pc  = npc;
      ex_rd_sel   = rd;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " a_valid"},  64'(a_valid),      64'h0);
      check({tag, " a_dm_we"},  64'(a_dm_we),      64'h0);
      check({tag, " a_rf_we"},  64'(a_rf_we),      64'h0);
      check({tag, " a_alu"},    64'(a_alu_res),    64'h0);
      check({tag, " a_muxb"},   64'(a_muxb),       64'h0);
      check({tag, " a_addr"},   64'(a_dm_addr),    64'h0);
      check({tag, " a_dsel"},   64'(a_rf_d_sel),   64'h0);
      check({tag, " a_npc"},    64'(a_next_pc),    64'h0);
      check({tag, " a_rd"},     64'(a_rd_sel),     64'h0);
      check({tag, " a_scnt"},   64'(a_stall_cnt),  64'h0);
      check({tag, " a_bcnt"},   64'(a_bubble_cnt), 64'h0);
      check({tag, " b_valid"},  64'(b_valid),      64'h0);
      check({tag, " b_alu"},    64'(b_alu_res),    64'h0);
      check({tag, " b_scnt"},   64'(b_stall_cnt),  64'h0);
      check({tag, " b_bcnt"},   64'(b_bubble_cnt), 64'h0);
   endtask

   initial begin
      // 1: reset for two cycles with random EX inputs and stall/flush active.
      rst = 1'b1; stall = 1'b1; flush = 1'b1; cnt_clr = 1'b0;
      set_ex(1'b1, 1'b1, 1'b1, $urandom, $urandom, 16'($urandom),
             2'($urandom), $urandom, 2'($urandom));
      step();
      step();
      check_zero("reset");

      // 2: plain load of a valid store instruction.
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      set_ex(1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'hCAFE_BABE, 16'h1234,
             2'd1, 32'h0000_0101, 2'd2);
      step();
      check("load a_valid", 64'(a_valid),    64'h1);
      check("load a_dm_we", 64'(a_dm_we),    64'h1);
      check("load a_rf_we", 64'(a_rf_we),    64'h0);
      check("load a_alu",   64'(a_alu_res),  64'h1234_5678);
      check("load a_muxb",  64'(a_muxb),     64'hCAFE_BABE);
      check("load a_addr",  64'(a_dm_addr),  64'h1234);
      check("load a_dsel",  64'(a_rf_d_sel), 64'h1);
      check("load a_npc",   64'(a_next_pc),  64'h101);
      check("load a_rd",    64'(a_rd_sel),   64'h2);
      check("load b_alu",   64'(b_alu_res),  64'h1234_5678);
      check("load a_bcnt",  64'(a_bubble_cnt), 64'h0);

      // 3: stall three cycles while EX inputs change; everything holds.
      stall = 1'b1;
      set_ex(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 16'hFFFF,
             2'd3, 32'h0000_0999, 2'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall a_valid", 64'(a_valid),   64'h1);
         check("stall a_dm_we", 64'(a_dm_we),   64'h1);
         check("stall a_alu",   64'(a_alu_res), 64'h1234_5678);
         check("stall a_rd",    64'(a_rd_sel),  64'h2);
         check("stall b_alu",   64'(b_alu_res), 64'h1234_5678);
      end
      check("stall a_scnt", 64'(a_stall_cnt),  64'h3);
      check("stall b_scnt", 64'(b_stall_cnt),  64'h3);
      check("stall a_bcnt", 64'(a_bubble_cnt), 64'h0);

      // 4: stall and flush together; flush wins, only bubble_cnt moves.
      flush = 1'b1;
      set_ex(1'b1, 1'b1, 1'b1, 32'h0000_0055, 32'h2, 16'h3, 2'd1, 32'h4, 2'd1);
      step();
      check("flush a_valid", 64'(a_valid),      64'h0);
      check("flush a_dm_we", 64'(a_dm_we),      64'h0);
      check("flush a_rf_we", 64'(a_rf_we),      64'h0);
      check("flush a_alu",   64'(a_alu_res),    64'h1234_5678);
      check("flush b_alu",   64'(b_alu_res),    64'h0);
      check("flush b_rd",    64'(b_rd_sel),     64'h0);
      check("flush a_bcnt",  64'(a_bubble_cnt), 64'h1);
      check("flush a_scnt",  64'(a_stall_cnt),  64'h3);

      // Reload a valid instruction with both enables set.
      stall = 1'b0; flush = 1'b0;
      set_ex(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 16'h00F0,
             2'd2, 32'h0000_0200, 2'd3);
      step();
      check("reload a_rf_we", 64'(a_rf_we),   64'h1);
      check("reload b_alu",   64'(b_alu_res), 64'hA5A5_A5A5);
      check("reload b_rd",    64'(b_rd_sel),  64'h3);

      // 5: invalid instruction with enables set; enables squashed.
      set_ex(1'b0, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h7, 16'h8, 2'd3, 32'h9, 2'd1);
      step();
      check("inv a_valid", 64'(a_valid),      64'h0);
      check("inv a_dm_we", 64'(a_dm_we),      64'h0);
      check("inv a_rf_we", 64'(a_rf_we),      64'h0);
      check("inv a_alu",   64'(a_alu_res),    64'h0BAD_F00D);
      check("inv b_alu",   64'(b_alu_res),    64'h0);
      check("inv b_dm_we", 64'(b_dm_we),      64'h0);
      check("inv a_bcnt",  64'(a_bubble_cnt), 64'h2);
      check("inv b_bcnt",  64'(b_bubble_cnt), 64'h2);

      // Reset asserted mid-stall, then the first load proceeds normally.
      set_ex(1'b1, 1'b1, 1'b1, 32'h3333_3333, 32'h4, 16'h5, 2'd1, 32'h6, 2'd2);
      step();
      stall = 1'b1; rst = 1'b1;
      step();
      check_zero("rst_mid_stall");
      stall = 1'b0; rst = 1'b0;
      set_ex(1'b1, 1'b0, 1'b1, 32'h0000_0077, 32'h8, 16'h9, 2'd2, 32'hA, 2'd1);
      step();
      check("post_rst a_valid", 64'(a_valid),   64'h1);
      check("post_rst a_rf_we", 64'(a_rf_we),   64'h1);
      check("post_rst a_alu",   64'(a_alu_res), 64'h77);
      check("post_rst a_npc",   64'(a_next_pc), 64'hA);

      // 6: saturation of the 4-bit counters and cnt_clr priority.
      stall = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("sat b_scnt", 64'(b_stall_cnt), 64'hF);
      check("sat a_scnt", 64'(a_stall_cnt), 64'd20);
      cnt_clr = 1'b1;
      step();
      check("clr b_scnt", 64'(b_stall_cnt), 64'h0);
      check("clr a_scnt", 64'(a_stall_cnt), 64'h0);
      cnt_clr = 1'b0; stall = 1'b0; flush = 1'b1;
      for (int i = 0; i < 18; i++) step();
      check("sat b_bcnt", 64'(b_bubble_cnt), 64'hF);
      check("sat a_bcnt", 64'(a_bubble_cnt), 64'd18);
      check("sat a_scnt", 64'(a_stall_cnt),  64'h0);
      cnt_clr = 1'b1;
      step();
      check("clr b_bcnt", 64'(b_bubble_cnt), 64'h0);
      check("clr a_bcnt", 64'(a_bubble_cnt), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
